// File: rtl/vrf_operand_router.sv
// Routes granted VRF bank reads to their destination operand queues through the
// fixed-latency read pipeline, bounding outstanding reads per queue.

module vrf_tag_pipe #(
   parameter int unsigned Stages = 1,
   parameter int unsigned QW     = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic [QW-1:0] qid_i,
   output logic          vld_o,
   output logic [QW-1:0] qid_o
);

   logic [Stages-1:0]         vld_q, vld_d;
   logic [Stages-1:0][QW-1:0] qid_q, qid_d;

   // Shift left by one stage; stage 0 takes the new tag.
   always_comb begin
      vld_d = Stages'({vld_q, load_i});
      qid_d = (Stages*QW)'({qid_q, qid_i});
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) vld_q <= '0;
      else         vld_q <= vld_d;
   end

   always_ff @(posedge clk_i) begin
      qid_q <= qid_d;
   end

   assign vld_o = vld_q[Stages-1];
   assign qid_o = qid_q[Stages-1];

endmodule

module vrf_operand_router #(
   parameter int unsigned NrBanks         = 8,
   parameter int unsigned NrOperandQueues = 9,
   parameter int unsigned VrfReadLatency  = 1,
   parameter int unsigned MaxInFlight     = 4,
   parameter int unsigned ElenW           = 64,
   localparam int unsigned QW             = $clog2(NrOperandQueues),
   localparam int unsigned CW             = $clog2(MaxInFlight+1)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NrBanks-1:0]                    read_req_valid_i,
   input  logic [NrBanks-1:0][QW-1:0]            read_req_queue_i,
   output logic [NrBanks-1:0]                    read_req_ready_o,
   input  logic [NrOperandQueues-1:0]            queue_ready_i,
   input  logic [NrBanks-1:0][ElenW-1:0]         bank_rdata_i,
   output logic [NrOperandQueues-1:0][ElenW-1:0] operand_o,
   output logic [NrOperandQueues-1:0]            operand_valid_o,
   output logic [NrOperandQueues-1:0]            operand_issued_o,
   output logic [NrOperandQueues-1:0][CW-1:0]    inflight_o
);

   localparam logic [CW-1:0] MaxCnt = CW'(MaxInFlight);
   localparam logic [QW:0]   NumQ   = (QW+1)'(NrOperandQueues);

   logic [NrOperandQueues-1:0][CW-1:0]    inflight_q, inflight_d;
   logic [NrOperandQueues-1:0]            operand_valid_q, operand_valid_d;
   logic [NrOperandQueues-1:0][ElenW-1:0] operand_q, operand_d;
   logic [NrBanks-1:0]                    ready;
   logic [NrOperandQueues-1:0]            issued;
   logic [NrBanks-1:0]                    tag_vld;
   logic [NrBanks-1:0][QW-1:0]            tag_qid;
   logic [NrOperandQueues-1:0][NrBanks-1:0] ret_hit;

   // Any lower bank requesting the same queue wins, whether or not it is itself ready.
   always_comb begin
      ready = '0;
      for (int b = 0; b < NrBanks; b++) begin
         if (rst_ni && read_req_valid_i[b] && ({1'b0, read_req_queue_i[b]} < NumQ)) begin
            if (queue_ready_i[read_req_queue_i[b]] &&
                (inflight_q[read_req_queue_i[b]] < MaxCnt)) ready[b] = 1'b1;
            for (int p = 0; p < b; p++) begin
               if (read_req_valid_i[p] && (read_req_queue_i[p] == read_req_queue_i[b]))
                  ready[b] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      issued = '0;
      for (int b = 0; b < NrBanks; b++) begin
         for (int q = 0; q < NrOperandQueues; q++) begin
            if (ready[b] && (read_req_queue_i[b] == QW'(q))) issued[q] = 1'b1;
         end
      end
   end

   for (genvar b = 0; b < NrBanks; b++) begin : g_bank
      vrf_tag_pipe #(
         .Stages (VrfReadLatency),
         .QW     (QW)
      ) i_tag_pipe (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .load_i (ready[b]),
         .qid_i  (read_req_queue_i[b]),
         .vld_o  (tag_vld[b]),
         .qid_o  (tag_qid[b])
      );
   end

   always_comb begin
      ret_hit         = '0;
      operand_valid_d = '0;
      operand_d       = operand_q;
      for (int q = 0; q < NrOperandQueues; q++) begin
         for (int b = 0; b < NrBanks; b++) begin
            if (tag_vld[b] && (tag_qid[b] == QW'(q))) begin
               ret_hit[q][b]      = 1'b1;
               operand_valid_d[q] = 1'b1;
               operand_d[q]       = bank_rdata_i[b];
            end
         end
      end
   end

   // A delivery frees its slot only once the registered strobe is seen.
   always_comb begin
      inflight_d = inflight_q;
      for (int q = 0; q < NrOperandQueues; q++) begin
         case ({issued[q], operand_valid_q[q]})
            2'b10:   inflight_d[q] = inflight_q[q] + CW'(1);
            2'b01:   inflight_d[q] = inflight_q[q] - CW'(1);
            default: inflight_d[q] = inflight_q[q];
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         inflight_q      <= '0;
         operand_valid_q <= '0;
         operand_q       <= '0;
      end else begin
         inflight_q      <= inflight_d;
         operand_valid_q <= operand_valid_d;
         operand_q       <= operand_d;
      end
   end

   assign read_req_ready_o = ready;
   assign operand_issued_o = issued;
   assign operand_valid_o  = operand_valid_q;
   assign operand_o        = operand_q;
   assign inflight_o       = inflight_q;

   for (genvar b = 0; b < NrBanks; b++) begin : g_chk_bank
      a_qid_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
         read_req_valid_i[b] |-> ({1'b0, read_req_queue_i[b]} < NumQ));
   end

   for (genvar q = 0; q < NrOperandQueues; q++) begin : g_chk_queue
      a_one_return: assert property (@(posedge clk_i) disable iff (!rst_ni)
         $onehot0(ret_hit[q]));
      a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
         operand_valid_q[q] |-> (inflight_q[q] != '0));
      a_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
         inflight_q[q] <= MaxCnt);
   end

endmodule

// File: tb/tb_vrf_operand_router.sv
// Bench for vrf_operand_router: two instances (read latency 1 and 3) driven with the
// same stimulus and checked every cycle against a history-based delivery model.

module tb_vrf_operand_router;

   localparam int NB = 8, NQ = 9, QW = 4, CW = 3, EW = 64, MAXF = 4, NCYC = 2600;
   localparam int AluA = 0, MulFPUA = 3, StA = 6, MaskB = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst_n = 1'b0;
   logic [NB-1:0]           req_v = '0;
   logic [NB-1:0][QW-1:0]   req_q = '0;
   logic [NQ-1:0]           qrdy  = '1;
   logic [NB-1:0][EW-1:0]   rdata = '0;

   logic [NB-1:0]           rdy_w [2];
   logic [NQ-1:0][EW-1:0]   opd_w [2];
   logic [NQ-1:0]           vld_w [2];
   logic [NQ-1:0]           iss_w [2];
   logic [NQ-1:0][CW-1:0]   inf_w [2];

   vrf_operand_router #(.VrfReadLatency(1)) dut_l1 (
      .clk_i(clk), .rst_ni(rst_n), .read_req_valid_i(req_v), .read_req_queue_i(req_q),
      .read_req_ready_o(rdy_w[0]), .queue_ready_i(qrdy), .bank_rdata_i(rdata),
      .operand_o(opd_w[0]), .operand_valid_o(vld_w[0]), .operand_issued_o(iss_w[0]),
      .inflight_o(inf_w[0]));

   vrf_operand_router #(.VrfReadLatency(3)) dut_l3 (
      .clk_i(clk), .rst_ni(rst_n), .read_req_valid_i(req_v), .read_req_queue_i(req_q),
      .read_req_ready_o(rdy_w[1]), .queue_ready_i(qrdy), .bank_rdata_i(rdata),
      .operand_o(opd_w[1]), .operand_valid_o(vld_w[1]), .operand_issued_o(iss_w[1]),
      .inflight_o(inf_w[1]));

   int checks = 0, errors = 0, cyc = 0;

   bit                    s_rst;
   logic [NB-1:0]         s_v;
   logic [NB-1:0][QW-1:0] s_q;
   logic [NQ-1:0]         s_qr;
   bit                    force_rd;
   logic [EW-1:0]         force_val;

   bit                    rst_h [NCYC];
   logic [NB-1:0][EW-1:0] rd_h  [NCYC];
   bit                    acc_v [2][NCYC][NB];
   logic [QW-1:0]         acc_q [2][NCYC][NB];
   logic [EW-1:0]         exp_op [2][NQ];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // No reset cycle strictly between accept t and cycle c.
   function automatic bit no_rst(int t, int c);
      for (int r = t + 1; r < c; r++) if (rst_h[r]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_check(int k);
      int                    lat;
      int                    c;
      int                    infl [NQ];
      bit                    lose;
      int                    t0;
      logic [NB-1:0]         er;
      logic [NQ-1:0]         ei, ev;
      logic [NQ-1:0][CW-1:0] einf;
      string                 tag;
      lat = (k == 0) ? 1 : 3;
      c   = cyc;
      tag = (k == 0) ? "L1" : "L3";
      for (int q = 0; q < NQ; q++) infl[q] = 0;
      // Outstanding = accepted before c, delivered no earlier than c, not wiped by reset.
      for (int t = c - lat - 1; t < c; t++)
         if (t >= 0 && no_rst(t, c))
            for (int b = 0; b < NB; b++) if (acc_v[k][t][b]) infl[acc_q[k][t][b]]++;
      er = '0;
      ei = '0;
      for (int b = 0; b < NB; b++) begin
         if (!rst_h[c] && s_v[b] && s_qr[s_q[b]] && infl[s_q[b]] < MAXF) begin
            lose = 1'b0;
            for (int p = 0; p < b; p++) if (s_v[p] && s_q[p] == s_q[b]) lose = 1'b1;
            if (!lose) begin
               er[b] = 1'b1;
               ei[s_q[b]] = 1'b1;
            end
         end
         acc_v[k][c][b] = er[b];
         acc_q[k][c][b] = s_q[b];
      end
      chk({tag, " ready"}, 64'(rdy_w[k]), 64'(er));
      chk({tag, " issued"}, 64'(iss_w[k]), 64'(ei));
      if (c > 0) begin
         if (rst_h[c-1]) for (int q = 0; q < NQ; q++) exp_op[k][q] = '0;
         ev = '0;
         t0 = c - lat - 1;
         if (t0 >= 0 && no_rst(t0, c))
            for (int b = 0; b < NB; b++)
               if (acc_v[k][t0][b]) begin
                  ev[acc_q[k][t0][b]] = 1'b1;
                  exp_op[k][acc_q[k][t0][b]] = rd_h[t0+lat][b];
               end
         for (int q = 0; q < NQ; q++) einf[q] = CW'(infl[q]);
         chk({tag, " valid"}, 64'(vld_w[k]), 64'(ev));
         chk({tag, " inflight"}, 64'(inf_w[k]), 64'(einf));
         for (int q = 0; q < NQ; q++)
            chk($sformatf("%s operand[%0d]", tag, q), opd_w[k][q], exp_op[k][q]);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      rst_n = !s_rst;
      req_v = s_v;
      req_q = s_q;
      qrdy  = s_qr;
      for (int b = 0; b < NB; b++) rdata[b] = {$urandom, $urandom};
      if (force_rd) rdata[0] = force_val;
      rd_h[cyc]  = rdata;
      rst_h[cyc] = s_rst;
      #1;
      model_check(0);
      model_check(1);
      @(posedge clk);
      cyc++;
      if (cyc >= NCYC) begin
         $display("FAIL cycle budget exceeded cyc=%0d", cyc);
         $fatal(1);
      end
   endtask

   task automatic idle(int n);
      s_v = '0;
      repeat (n) tick();
   endtask

   initial begin
      s_rst = 1'b1; s_v = '0; s_q = '0; s_qr = '1; force_rd = 1'b0; force_val = '0;
      repeat (3) tick();
      s_rst = 1'b0;
      idle(2);

      // Single read, L=1: inflight 0->1->0, delivery at t+2
      s_v = 8'h01; s_q[0] = QW'(AluA);
      tick(); #1;
      chk("t1 inflight@t+1", 64'(inf_w[0][AluA]), 64'd1);
      s_v = '0; force_rd = 1'b1; force_val = 64'hDEADBEEF;
      tick(); #1;
      force_rd = 1'b0;
      chk("t1 valid@t+2", 64'(vld_w[0][AluA]), 64'd1);
      chk("t1 operand@t+2", opd_w[0][AluA], 64'hDEADBEEF);
      tick(); #1;
      chk("t1 inflight@t+3", 64'(inf_w[0][AluA]), 64'd0);
      idle(4);

      // Banks 2 and 5 on the same queue: one accept per cycle
      s_v = 8'h24; s_q[2] = QW'(MulFPUA); s_q[5] = QW'(MulFPUA);
      tick(); #1;
      chk("t2 inflight@t+1", 64'(inf_w[0][MulFPUA]), 64'd1);
      s_v = 8'h20;
      tick(); #1;
      chk("t2 inflight@t+2", 64'(inf_w[0][MulFPUA]), 64'd2);
      idle(5);

      // Back-to-back StA reads at L=3 saturate the in-flight bound
      s_v = 8'h01; s_q[0] = QW'(StA);
      repeat (4) tick();
      #1;
      chk("t3 inflight peak", 64'(inf_w[1][StA]), 64'd4);
      chk("t3 stalled", 64'(iss_w[1][StA]), 64'd0);
      tick(); #1;
      chk("t3 resumed", 64'(iss_w[1][StA]), 64'd1);
      tick();
      idle(6);

      // MaskB not ready: its bank stalls, another queue proceeds
      s_qr[MaskB] = 1'b0; s_v = 8'h0A; s_q[1] = QW'(MaskB); s_q[3] = QW'(AluA);
      tick(); #1;
      chk("t4 maskb blocked", 64'(rdy_w[0][1]), 64'd0);
      chk("t4 alua proceeds", 64'(rdy_w[0][3]), 64'd1);
      tick();
      s_qr = '1;
      idle(5);

      // Eight banks to eight distinct queues in one cycle
      s_v = 8'hFF;
      for (int b = 0; b < NB; b++) s_q[b] = QW'(b);
      tick();
      s_v = '0;
      tick(); #1;
      chk("t5 L1 all valid", 64'(vld_w[0]), 64'h0FF);
      tick(); tick(); #1;
      chk("t5 L3 all valid", 64'(vld_w[1]), 64'h0FF);
      idle(4);

      // Reset with three reads in flight drops them
      s_v = 8'h07; s_q[0] = 4'd0; s_q[1] = 4'd1; s_q[2] = 4'd2;
      tick();
      s_v = '0; s_rst = 1'b1;
      tick();
      s_rst = 1'b0;
      repeat (6) begin
         #1;
         chk("t6 L3 no valid", 64'(vld_w[1]), 64'd0);
         chk("t6 L1 no valid", 64'(vld_w[0]), 64'd0);
         chk("t6 L3 inflight", 64'(inf_w[1]), 64'd0);
         tick();
      end

      // Random traffic; first half on few queues to exercise the bound
      for (int i = 0; i < 2000; i++) begin
         s_rst = ($urandom_range(0, 199) == 0);
         for (int b = 0; b < NB; b++) begin
            s_v[b] = 1'($urandom_range(0, 1));
            s_q[b] = QW'($urandom_range(0, (i < 1000) ? 2 : NQ - 1));
         end
         for (int q = 0; q < NQ; q++) s_qr[q] = ($urandom_range(0, 7) != 0);
         tick();
      end
      s_rst = 1'b0;
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
